// File: rtl/config_register_bank.sv
// Double-buffered configuration register bank with a CONFIG/OPERATE/DRAIN mode FSM.
// Host writes land in the shadow bank; the datapath only ever sees the active bank.
module config_register_bank #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int MODE_BIT = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wen,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rdata,
  output logic                       rvalid,
  output logic [NUM_REGS*DATA_W-1:0] data_out,
  output logic                       op_mode,
  input  logic                       engine_busy,
  output logic                       cfg_err
);

  typedef enum logic [1:0] {
    ST_CONFIG  = 2'd0,
    ST_OPERATE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

  // One extra bit so NUM_REGS itself is representable when it is a power of two.
  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

  state_e            state;
  state_e            state_nx;
  logic [DATA_W-1:0] shadow [NUM_REGS];
  logic [DATA_W-1:0] active [NUM_REGS];

  logic addr_ok;
  logic wr_reg0;
  logic mode_req;
  logic shadow_we;
  logic commit;
  logic active0_we;
  logic reject;

  always_comb begin
    addr_ok  = ({1'b0, addr} < NUM_REGS_W);
    wr_reg0  = wen && (addr == '0);
    mode_req = data_in[MODE_BIT];
  end

  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx   = state;
    shadow_we  = 1'b0;
    commit     = 1'b0;
    active0_we = 1'b0;
    reject     = 1'b0;
    case (state)
      ST_CONFIG: begin
        if (wen) begin
          if (!addr_ok) begin
            reject = 1'b1;
          end else begin
            shadow_we = 1'b1;
            if (wr_reg0 && mode_req) begin
              commit   = 1'b1;
              state_nx = ST_OPERATE;
            end
          end
        end
      end
      ST_OPERATE: begin
        // Only clearing the mode bit in reg0 is legal while operating.
        if (wen) begin
          if (wr_reg0 && !mode_req) begin
            shadow_we  = 1'b1;
            active0_we = 1'b1;
            state_nx   = engine_busy ? ST_DRAIN : ST_CONFIG;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        reject = wen;
        if (!engine_busy) begin
          state_nx = ST_CONFIG;
        end
      end
      default: state_nx = ST_CONFIG;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_CONFIG;
    end else begin
      state <= state_nx;
    end
  end

  // NOTE: both banks are reset (not left as uninitialised storage) because the
  // datapath consumes the active bank directly and must see all-zero after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (shadow_we) begin
        shadow[addr] <= data_in;
      end
      if (commit) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          active[i] <= (i == 0) ? data_in : shadow[i];
        end
      end
      if (active0_we) begin
        active[0] <= data_in;
      end
    end
  end

  // NOTE: non-blocking assignments make rdata sample shadow before any write at
  // the same edge takes effect, giving read-before-write for free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata   <= '0;
      rvalid  <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      rvalid  <= rd_en;
      cfg_err <= reject;
      if (rd_en) begin
        rdata <= addr_ok ? shadow[addr] : '0;
      end
    end
  end

  always_comb begin
    data_out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      data_out[i*DATA_W +: DATA_W] = active[i];
    end
    op_mode = (state == ST_OPERATE);
  end

endmodule

// File: tb/tb_config_register_bank.sv
// Bench for config_register_bank: directed vector table, hand sequences for the
// 3-register instance and mid-DRAIN reset, then random traffic against a model.
module tb_config_register_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic         wen, rd_en, busy;
  logic [1:0]   addr;
  logic [31:0]  din, rdata;
  logic         rvalid, op_mode, cfg_err;
  logic [127:0] dout;

  logic         wen_b, rd_en_b, busy_b;
  logic [1:0]   addr_b;
  logic [31:0]  din_b, rdata_b;
  logic         rvalid_b, op_mode_b, cfg_err_b;
  logic [95:0]  dout_b;

  config_register_bank #(.DATA_W(32), .NUM_REGS(4), .MODE_BIT(0)) dut (
    .clk(clk), .rst(rst), .wen(wen), .addr(addr), .data_in(din), .rd_en(rd_en),
    .rdata(rdata), .rvalid(rvalid), .data_out(dout), .op_mode(op_mode),
    .engine_busy(busy), .cfg_err(cfg_err)
  );

  config_register_bank #(.DATA_W(32), .NUM_REGS(3), .MODE_BIT(0)) dut3 (
    .clk(clk), .rst(rst), .wen(wen_b), .addr(addr_b), .data_in(din_b), .rd_en(rd_en_b),
    .rdata(rdata_b), .rvalid(rvalid_b), .data_out(dout_b), .op_mode(op_mode_b),
    .engine_busy(busy_b), .cfg_err(cfg_err_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        wen;
    logic [1:0]  addr;
    logic [31:0] data;
    logic        rd;
    logic        busy;
    logic [31:0] e_rdata;
    logic        e_rvalid;
    logic        e_op;
    logic        e_err;
    logic [31:0] e_r0;
    logic [31:0] e_r1;
  } vec_t;

  vec_t vecs [15];

  typedef enum {M_CFG, M_OPR, M_DRN} mmode_e;
  mmode_e      m_mode;
  logic [31:0] m_sh [4];
  logic [31:0] m_ac [4];
  logic [31:0] m_rdata;
  logic        m_rvalid;
  logic        m_err;
  logic [127:0] m_dout;

  initial begin
    vecs[0]  = '{1'b1, 2'd1, 32'hCAFECAF0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[1]  = '{1'b0, 2'd1, 32'h0,        1'b1, 1'b0, 32'hCAFECAF0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[2]  = '{1'b1, 2'd0, 32'hCAFECAF1, 1'b0, 1'b0, 32'hCAFECAF0, 1'b0, 1'b1, 1'b0, 32'hCAFECAF1, 32'hCAFECAF0};
    vecs[3]  = '{1'b1, 2'd1, 32'hCAFECAFE, 1'b0, 1'b0, 32'hCAFECAF0, 1'b0, 1'b1, 1'b1, 32'hCAFECAF1, 32'hCAFECAF0};
    vecs[4]  = '{1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 32'hCAFECAF0, 1'b0, 1'b1, 1'b0, 32'hCAFECAF1, 32'hCAFECAF0};
    vecs[5]  = '{1'b1, 2'd0, 32'hCAFECAFF, 1'b0, 1'b0, 32'hCAFECAF0, 1'b0, 1'b1, 1'b1, 32'hCAFECAF1, 32'hCAFECAF0};
    vecs[6]  = '{1'b0, 2'd1, 32'h0,        1'b1, 1'b0, 32'hCAFECAF0, 1'b1, 1'b1, 1'b0, 32'hCAFECAF1, 32'hCAFECAF0};
    vecs[7]  = '{1'b1, 2'd0, 32'h0,        1'b0, 1'b1, 32'hCAFECAF0, 1'b0, 1'b0, 1'b0, 32'h0,        32'hCAFECAF0};
    vecs[8]  = '{1'b1, 2'd2, 32'h1234,     1'b0, 1'b1, 32'hCAFECAF0, 1'b0, 1'b0, 1'b1, 32'h0,        32'hCAFECAF0};
    vecs[9]  = '{1'b0, 2'd0, 32'h0,        1'b0, 1'b1, 32'hCAFECAF0, 1'b0, 1'b0, 1'b0, 32'h0,        32'hCAFECAF0};
    vecs[10] = '{1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 32'hCAFECAF0, 1'b0, 1'b0, 1'b0, 32'h0,        32'hCAFECAF0};
    vecs[11] = '{1'b1, 2'd0, 32'hFACEFAC1, 1'b0, 1'b0, 32'hCAFECAF0, 1'b0, 1'b1, 1'b0, 32'hFACEFAC1, 32'hCAFECAF0};
    vecs[12] = '{1'b1, 2'd0, 32'h0,        1'b1, 1'b0, 32'hFACEFAC1, 1'b1, 1'b0, 1'b0, 32'h0,        32'hCAFECAF0};
    vecs[13] = '{1'b1, 2'd1, 32'h5,        1'b0, 1'b0, 32'hFACEFAC1, 1'b0, 1'b0, 1'b0, 32'h0,        32'hCAFECAF0};
    vecs[14] = '{1'b0, 2'd1, 32'h0,        1'b1, 1'b0, 32'h5,        1'b1, 1'b0, 1'b0, 32'h0,        32'hCAFECAF0};

    rst = 1'b0;
    wen = 1'b0; rd_en = 1'b0; busy = 1'b0; addr = '0; din = '0;
    wen_b = 1'b0; rd_en_b = 1'b0; busy_b = 1'b0; addr_b = '0; din_b = '0;

    #12;
    check("reset op_mode", 128'(op_mode), 128'(0));
    check("reset rdata", 128'(rdata), 128'(0));
    check("reset rvalid", 128'(rvalid), 128'(0));
    check("reset cfg_err", 128'(cfg_err), 128'(0));
    check("reset data_out", dout, 128'(0));
    check("reset data_out3", 128'(dout_b), 128'(0));

    @(negedge clk);
    rst = 1'b1;
    step();

    // Directed vector table on the 4-register instance.
    for (int i = 0; i < 15; i++) begin
      wen = vecs[i].wen; addr = vecs[i].addr; din = vecs[i].data;
      rd_en = vecs[i].rd; busy = vecs[i].busy;
      step();
      check($sformatf("vec%0d rdata", i), 128'(rdata), 128'(vecs[i].e_rdata));
      check($sformatf("vec%0d rvalid", i), 128'(rvalid), 128'(vecs[i].e_rvalid));
      check($sformatf("vec%0d op_mode", i), 128'(op_mode), 128'(vecs[i].e_op));
      check($sformatf("vec%0d cfg_err", i), 128'(cfg_err), 128'(vecs[i].e_err));
      check($sformatf("vec%0d reg0", i), 128'(dout[31:0]), 128'(vecs[i].e_r0));
      check($sformatf("vec%0d reg1", i), 128'(dout[63:32]), 128'(vecs[i].e_r1));
    end
    wen = 1'b0; rd_en = 1'b0;

    // Three-register instance: out-of-range address and read-before-write.
    wen_b = 1'b1; addr_b = 2'd2; din_b = 32'h11;
    step();
    check("b wr2 cfg_err", 128'(cfg_err_b), 128'(0));
    wen_b = 1'b0; rd_en_b = 1'b1; addr_b = 2'd2;
    step();
    check("b rd2 rdata", 128'(rdata_b), 128'(32'h11));
    rd_en_b = 1'b0; wen_b = 1'b1; addr_b = 2'd3; din_b = 32'hFFFF;
    step();
    check("b wr3 cfg_err", 128'(cfg_err_b), 128'(1));
    check("b wr3 data_out", 128'(dout_b), 128'(0));
    wen_b = 1'b0; rd_en_b = 1'b1; addr_b = 2'd3;
    step();
    check("b rd3 rdata", 128'(rdata_b), 128'(0));
    check("b rd3 rvalid", 128'(rvalid_b), 128'(1));
    check("b rd3 cfg_err", 128'(cfg_err_b), 128'(0));
    wen_b = 1'b1; rd_en_b = 1'b1; addr_b = 2'd2; din_b = 32'h22;
    step();
    check("b rbw rdata", 128'(rdata_b), 128'(32'h11));
    wen_b = 1'b0; rd_en_b = 1'b1; addr_b = 2'd2;
    step();
    check("b rd2 new rdata", 128'(rdata_b), 128'(32'h22));
    rd_en_b = 1'b0; wen_b = 1'b1; addr_b = 2'd0; din_b = 32'h1;
    step();
    check("b commit op_mode", 128'(op_mode_b), 128'(1));
    check("b commit data_out", 128'(dout_b), 128'(96'h00000022_00000000_00000001));
    check("b commit rvalid", 128'(rvalid_b), 128'(0));
    wen_b = 1'b1; addr_b = 2'd1; din_b = 32'h9;
    step();
    check("b rej1 cfg_err", 128'(cfg_err_b), 128'(1));
    step();
    check("b rej2 cfg_err", 128'(cfg_err_b), 128'(1));
    wen_b = 1'b0;
    step();
    check("b rej end cfg_err", 128'(cfg_err_b), 128'(0));
    check("b rej data_out", 128'(dout_b), 128'(96'h00000022_00000000_00000001));

    // Asynchronous reset in the middle of DRAIN.
    wen = 1'b1; addr = 2'd0; din = 32'h1; busy = 1'b0;
    step();
    check("drain commit reg1", 128'(dout[63:32]), 128'(32'h5));
    busy = 1'b1; din = 32'h0;
    step();
    check("drain enter op_mode", 128'(op_mode), 128'(0));
    wen = 1'b1; addr = 2'd1; din = 32'h7; rd_en = 1'b1;
    step();
    check("drain rej cfg_err", 128'(cfg_err), 128'(1));
    check("drain rd rvalid", 128'(rvalid), 128'(1));
    wen = 1'b0; rd_en = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    check("async rst cfg_err", 128'(cfg_err), 128'(0));
    check("async rst rvalid", 128'(rvalid), 128'(0));
    check("async rst op_mode", 128'(op_mode), 128'(0));
    check("async rst data_out", dout, 128'(0));
    step();
    rst = 1'b1;
    wen = 1'b1; addr = 2'd0; din = 32'h1;
    step();
    check("post rst commit op_mode", 128'(op_mode), 128'(1));
    check("post rst data_out", dout, 128'(1));
    wen = 1'b0;

    // Randomised traffic against the reference model.
    rst = 1'b0;
    #1;
    rst = 1'b1;
    m_mode = M_CFG;
    m_rdata = '0;
    for (int k = 0; k < 4; k++) begin
      m_sh[k] = '0;
      m_ac[k] = '0;
    end
    for (int n = 0; n < 400; n++) begin
      mmode_e prev;
      wen   = 1'($urandom_range(0, 1));
      rd_en = 1'($urandom_range(0, 1));
      addr  = ($urandom_range(0, 1) == 1) ? 2'd0 : 2'($urandom_range(0, 3));
      din   = $urandom;
      din[0] = 1'($urandom_range(0, 1));
      busy  = 1'($urandom_range(0, 1));

      m_rvalid = rd_en;
      if (rd_en) m_rdata = m_sh[addr];
      m_err = 1'b0;
      prev = m_mode;
      if (wen) begin
        if (prev == M_CFG) begin
          m_sh[addr] = din;
          if (addr == 0 && din[0]) begin
            m_ac = m_sh;
            m_mode = M_OPR;
          end
        end else if (prev == M_OPR && addr == 0 && !din[0]) begin
          m_sh[0] = din;
          m_ac[0] = din;
          m_mode = busy ? M_DRN : M_CFG;
        end else begin
          m_err = 1'b1;
        end
      end
      if (prev == M_DRN && !busy) m_mode = M_CFG;
      for (int k = 0; k < 4; k++) m_dout[k*32 +: 32] = m_ac[k];

      step();
      check($sformatf("rnd%0d rdata", n), 128'(rdata), 128'(m_rdata));
      check($sformatf("rnd%0d rvalid", n), 128'(rvalid), 128'(m_rvalid));
      check($sformatf("rnd%0d op_mode", n), 128'(op_mode), 128'(m_mode == M_OPR));
      check($sformatf("rnd%0d cfg_err", n), 128'(cfg_err), 128'(m_err));
      check($sformatf("rnd%0d data_out", n), dout, m_dout);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
